axi_to_stream_dma_2d: RTL and testbench

Parametrised AXI4 read-master DMA that fetches a 2D frame from memory and emits it as a packetised stream. A frame is LINES lines of LINE_WORDS data beats, with a programmable byte stride between line starts. It adds single-shot or continuous-frame mode, line-end-truncated bursts, multiple outstanding reads and a readable status/error register. It sits between the DDR AXI interconnect and the video pixel pipeline, and is programmed over the Avalon-MM control bus.

---
 rtl/axi_to_stream_dma_2d.sv | 244 ++++++++++++++++++++++++
 tb/tb_axi_to_stream_dma_2d.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_to_stream_dma_2d.sv
// 2D frame fetcher: AXI4 read master that walks LINES x LINE_WORDS beats with a byte stride
// and forwards the read data as a packetised stream with SOP/EOL/EOP markers.
module axi_to_stream_dma_2d #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned BURST_LEN       = 16,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned LEN_WIDTH       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] mst_axi_araddr,
  output logic [7:0]            mst_axi_arlen,
  output logic [2:0]            mst_axi_arsize,
  output logic [1:0]            mst_axi_arburst,
  output logic [3:0]            mst_axi_arid,
  output logic                  mst_axi_arvalid,
  input  logic                  mst_axi_arready,
  input  logic [DATA_WIDTH-1:0] mst_axi_rdata,
  input  logic [1:0]            mst_axi_rresp,
  input  logic                  mst_axi_rlast,
  input  logic                  mst_axi_rvalid,
  output logic                  mst_axi_rready,
  output logic [DATA_WIDTH-1:0] st_data,
  output logic                  st_valid,
  output logic                  st_startofpacket,
  output logic                  st_endofpacket,
  output logic                  st_endofline,
  input  logic                  st_ready,
  input  logic [4:0]            ctrl_address,
  input  logic                  ctrl_read,
  output logic [31:0]           ctrl_readdata,
  output logic                  ctrl_readdatavalid,
  input  logic                  ctrl_write,
  input  logic [31:0]           ctrl_writedata,
  output logic                  ctrl_waitrequest,
  output logic                  irq_frame
);
  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned OST_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] start_addr_q, stride_q, sh_stride_q, line_base_q, req_addr_q;
  logic [LEN_WIDTH-1:0]  line_words_q, lines_q, sh_lw_q, sh_lines_q;
  logic [LEN_WIDTH-1:0]  req_rem_q, req_line_q, beat_q, line_q;
  logic                  en_q, cont_q, err_q, last_seen_q;
  logic [15:0]           frame_cnt_q;
  logic [OST_W-1:0]      ost_q;

  logic        ar_hs_c, r_hs_c, rlast_hs_c, cfg_ok_c, line_end_c, last_req_c;
  logic        load_c, issue_c, done_c, abort_c, busy_c, eol_c, eop_c;
  logic [31:0] rem_c, beats_c;

  assign mst_axi_arsize   = 3'($clog2(BYTES));
  assign mst_axi_arburst  = 2'b01;
  assign mst_axi_arid     = 4'd0;
  assign ctrl_waitrequest = 1'b0;

  // Stream side is a straight pass-through of the R channel
  assign st_data          = mst_axi_rdata;
  assign st_valid         = mst_axi_rvalid;
  assign mst_axi_rready   = st_ready;
  assign eol_c            = mst_axi_rvalid && (beat_q == sh_lw_q - LEN_WIDTH'(1));
  assign eop_c            = eol_c && (line_q == sh_lines_q - LEN_WIDTH'(1));
  assign st_endofline     = eol_c;
  assign st_endofpacket   = eop_c;
  assign st_startofpacket = mst_axi_rvalid && (beat_q == '0) && (line_q == '0);

  assign ar_hs_c    = mst_axi_arvalid && mst_axi_arready;
  assign r_hs_c     = mst_axi_rvalid && st_ready;
  assign rlast_hs_c = r_hs_c && mst_axi_rlast;
  assign cfg_ok_c   = (line_words_q != '0) && (lines_q != '0);
  assign busy_c     = (state_q != IDLE) || (ost_q != '0);

  // Burst is clipped to the end of the current line
  assign rem_c      = 32'(req_rem_q);
  assign beats_c    = (rem_c > BURST_LEN) ? BURST_LEN : rem_c;
  assign line_end_c = (beats_c == rem_c);
  assign last_req_c = line_end_c && (req_line_q == sh_lines_q - LEN_WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    issue_c = 1'b0;
    done_c  = 1'b0;
    abort_c = 1'b0;
    unique case (state_q)
      IDLE: if (en_q && cfg_ok_c) begin
        state_d = REQ;
        load_c  = 1'b1;
      end
      REQ: begin
        if (mst_axi_arvalid) begin
          if (mst_axi_arready && last_req_c) state_d = DRAIN;
        end else if (!en_q) begin
          if (ost_q == '0) begin
            state_d = IDLE;
            abort_c = 1'b1;
          end
        end else if (ost_q < OST_W'(MAX_OUTSTANDING)) begin
          issue_c = 1'b1;
        end
      end
      DRAIN: if ((ost_q == '0) && last_seen_q) begin
        done_c = 1'b1;
        if (en_q && cont_q && cfg_ok_c) begin
          state_d = REQ;
          load_c  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Address generation; AR fields only change when no request is pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_lw_q         <= '0;
      sh_lines_q      <= '0;
      sh_stride_q     <= '0;
      line_base_q     <= '0;
      req_addr_q      <= '0;
      req_rem_q       <= '0;
      req_line_q      <= '0;
      mst_axi_arvalid <= 1'b0;
      mst_axi_araddr  <= '0;
      mst_axi_arlen   <= '0;
    end else if (load_c) begin
      sh_lw_q     <= line_words_q;
      sh_lines_q  <= lines_q;
      sh_stride_q <= stride_q;
      line_base_q <= start_addr_q;
      req_addr_q  <= start_addr_q;
      req_rem_q   <= line_words_q;
      req_line_q  <= '0;
    end else if (ar_hs_c) begin
      mst_axi_arvalid <= 1'b0;
      if (line_end_c) begin
        line_base_q <= line_base_q + sh_stride_q;
        req_addr_q  <= line_base_q + sh_stride_q;
        req_rem_q   <= sh_lw_q;
        req_line_q  <= req_line_q + LEN_WIDTH'(1);
      end else begin
        req_addr_q <= req_addr_q + ADDR_WIDTH'(beats_c * BYTES);
        req_rem_q  <= req_rem_q - LEN_WIDTH'(beats_c);
      end
    end else if (issue_c) begin
      mst_axi_arvalid <= 1'b1;
      mst_axi_araddr  <= req_addr_q;
      mst_axi_arlen   <= 8'(beats_c - 32'd1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ost_q <= '0;
    end else if (ar_hs_c && !rlast_hs_c) begin
      ost_q <= ost_q + OST_W'(1);
    end else if (!ar_hs_c && rlast_hs_c && (ost_q != '0)) begin
      ost_q <= ost_q - OST_W'(1);
    end
  end

  // Beat/line position of the stream within the frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q      <= '0;
      line_q      <= '0;
      last_seen_q <= 1'b0;
    end else begin
      if (abort_c) begin
        beat_q <= '0;
        line_q <= '0;
      end else if (r_hs_c) begin
        if (eol_c) begin
          beat_q <= '0;
          line_q <= eop_c ? '0 : line_q + LEN_WIDTH'(1);
        end else begin
          beat_q <= beat_q + LEN_WIDTH'(1);
        end
      end
      if (load_c)              last_seen_q <= 1'b0;
      else if (r_hs_c && eop_c) last_seen_q <= 1'b1;
    end
  end

  // Control registers; a single-shot frame clears enable when it completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_addr_q       <= '0;
      line_words_q       <= '0;
      lines_q            <= '0;
      stride_q           <= '0;
      en_q               <= 1'b0;
      cont_q             <= 1'b0;
      err_q              <= 1'b0;
      frame_cnt_q        <= '0;
      irq_frame          <= 1'b0;
      ctrl_readdata      <= '0;
      ctrl_readdatavalid <= 1'b0;
    end else begin
      irq_frame <= done_c;
      if (done_c) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (done_c && !cont_q) en_q <= 1'b0;
      if (ctrl_write) begin
        unique case (ctrl_address)
          5'h00: start_addr_q <= ADDR_WIDTH'(ctrl_writedata);
          5'h04: line_words_q <= LEN_WIDTH'(ctrl_writedata);
          5'h08: lines_q      <= LEN_WIDTH'(ctrl_writedata);
          5'h0C: stride_q     <= ADDR_WIDTH'(ctrl_writedata);
          5'h10: begin
            en_q   <= ctrl_writedata[0];
            cont_q <= ctrl_writedata[1];
            if (ctrl_writedata[2]) err_q <= 1'b0;
          end
          default: ;
        endcase
      end
      if (r_hs_c && (mst_axi_rresp != 2'b00)) err_q <= 1'b1;
      ctrl_readdatavalid <= ctrl_read;
      ctrl_readdata      <= '0;
      if (ctrl_read) begin
        unique case (ctrl_address)
          5'h00:   ctrl_readdata <= 32'(start_addr_q);
          5'h04:   ctrl_readdata <= 32'(line_words_q);
          5'h08:   ctrl_readdata <= 32'(lines_q);
          5'h0C:   ctrl_readdata <= 32'(stride_q);
          5'h10:   ctrl_readdata <= {30'd0, cont_q, en_q};
          5'h14:   ctrl_readdata <= {frame_cnt_q, 14'd0, err_q, busy_c};
          default: ctrl_readdata <= '0;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_axi_to_stream_dma_2d.sv
// Directed bench for axi_to_stream_dma_2d: AXI slave/memory model, stream and AR scoreboards.
module tb_axi_to_stream_dma_2d;
  typedef struct packed { logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct packed { logic [31:0] data; logic sop; logic eol; logic eop; } beat_t;

  logic        clk, rst;
  logic [31:0] mst_axi_araddr;
  logic [7:0]  mst_axi_arlen;
  logic [2:0]  mst_axi_arsize;
  logic [1:0]  mst_axi_arburst;
  logic [3:0]  mst_axi_arid;
  logic        mst_axi_arvalid, mst_axi_arready;
  logic [31:0] mst_axi_rdata;
  logic [1:0]  mst_axi_rresp;
  logic        mst_axi_rlast, mst_axi_rvalid, mst_axi_rready;
  logic [31:0] st_data;
  logic        st_valid, st_startofpacket, st_endofpacket, st_endofline, st_ready;
  logic [4:0]  ctrl_address;
  logic        ctrl_read, ctrl_readdatavalid, ctrl_write, ctrl_waitrequest, irq_frame;
  logic [31:0] ctrl_readdata, ctrl_writedata;

  axi_to_stream_dma_2d dut (
    .clk(clk), .rst(rst),
    .mst_axi_araddr(mst_axi_araddr), .mst_axi_arlen(mst_axi_arlen),
    .mst_axi_arsize(mst_axi_arsize), .mst_axi_arburst(mst_axi_arburst),
    .mst_axi_arid(mst_axi_arid), .mst_axi_arvalid(mst_axi_arvalid),
    .mst_axi_arready(mst_axi_arready), .mst_axi_rdata(mst_axi_rdata),
    .mst_axi_rresp(mst_axi_rresp), .mst_axi_rlast(mst_axi_rlast),
    .mst_axi_rvalid(mst_axi_rvalid), .mst_axi_rready(mst_axi_rready),
    .st_data(st_data), .st_valid(st_valid), .st_startofpacket(st_startofpacket),
    .st_endofpacket(st_endofpacket), .st_endofline(st_endofline), .st_ready(st_ready),
    .ctrl_address(ctrl_address), .ctrl_read(ctrl_read), .ctrl_readdata(ctrl_readdata),
    .ctrl_readdatavalid(ctrl_readdatavalid), .ctrl_write(ctrl_write),
    .ctrl_writedata(ctrl_writedata), .ctrl_waitrequest(ctrl_waitrequest),
    .irq_frame(irq_frame)
  );

  // Written by the slave/monitor process only
  ar_t   ar_obs[$];
  beat_t st_obs[$];
  int    irq_cnt, ar_stab_bad, rr_bad, rbeats;
  // Written by the main sequence only
  logic  r_en, bp_mode;
  int    err_beat;
  ar_t   exp_ar[$];
  beat_t exp_st[$];
  int    ar_rd, st_rd, n_vec, n_err, irq_exp;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Stream ready: all-ones or random backpressure
  initial begin
    st_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      st_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // AXI read slave plus AR/R/stream/irq monitors, sampled at negedge
  initial begin : slave
    ar_t         rsp_q[$];
    ar_t         cur, prev_ar, t;
    beat_t       b;
    logic        act, prev_pend;
    logic [31:0] a;
    int          left;
    irq_cnt = 0; ar_stab_bad = 0; rr_bad = 0; rbeats = 0;
    act = 1'b0; prev_pend = 1'b0; a = '0; left = 0; prev_ar = '0;
    mst_axi_rvalid = 1'b0; mst_axi_rdata = '0; mst_axi_rlast = 1'b0; mst_axi_rresp = 2'b00;
    forever begin
      @(negedge clk);
      if (mst_axi_arvalid) begin
        if (prev_pend && (mst_axi_araddr !== prev_ar.addr || mst_axi_arlen !== prev_ar.len))
          ar_stab_bad++;
        t.addr = mst_axi_araddr;
        t.len  = mst_axi_arlen;
        if (mst_axi_arready) begin
          ar_obs.push_back(t);
          rsp_q.push_back(t);
          prev_pend = 1'b0;
        end else begin
          prev_pend = 1'b1;
          prev_ar   = t;
        end
      end else if (prev_pend) begin
        ar_stab_bad++;
        prev_pend = 1'b0;
      end
      if (mst_axi_rready !== st_ready) rr_bad++;
      if (irq_frame) irq_cnt++;
      if (st_valid && st_ready) begin
        b.data = st_data; b.sop = st_startofpacket; b.eol = st_endofline; b.eop = st_endofpacket;
        st_obs.push_back(b);
      end
      if (mst_axi_rvalid && mst_axi_rready) begin
        rbeats++;
        a = a + 32'd4;
        left--;
        if (left == 0) act = 1'b0;
      end
      @(posedge clk); #1;
      if (!act && rsp_q.size() > 0) begin
        cur  = rsp_q.pop_front();
        act  = 1'b1;
        a    = cur.addr;
        left = int'(cur.len) + 1;
      end
      mst_axi_rvalid = r_en && act;
      mst_axi_rdata  = mem_fn(a);
      mst_axi_rlast  = act && (left == 1);
      mst_axi_rresp  = (mst_axi_rvalid && rbeats == err_beat) ? 2'b10 : 2'b00;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ctrl_wr(input logic [4:0] addr, input logic [31:0] data);
    ctrl_address = addr; ctrl_writedata = data; ctrl_write = 1'b1;
    tick();
    ctrl_write = 1'b0;
  endtask

  task automatic ctrl_rd(input logic [4:0] addr, output logic [31:0] data);
    ctrl_address = addr; ctrl_read = 1'b1;
    tick();
    ctrl_read = 1'b0;
    check("ctrl_rdvalid", 64'(ctrl_readdatavalid), 64'd1);
    data = ctrl_readdata;
  endtask

  task automatic push_frame(input logic [31:0] start, input int lw, input int nl,
                            input logic [31:0] stride, input int total_lines);
    beat_t       b;
    logic [31:0] a;
    for (int l = 0; l < nl; l++)
      for (int w = 0; w < lw; w++) begin
        a = start + 32'(l) * stride + 32'(w * 4);
        b.data = mem_fn(a);
        b.sop  = (l == 0) && (w == 0);
        b.eol  = (w == lw - 1);
        b.eop  = (w == lw - 1) && (l == total_lines - 1);
        exp_st.push_back(b);
      end
  endtask

  task automatic push_ars(input logic [31:0] start, input int lw, input int nl,
                          input logic [31:0] stride);
    ar_t         t;
    logic [31:0] a;
    int          rem, n;
    for (int l = 0; l < nl; l++) begin
      a = start + 32'(l) * stride;
      rem = lw;
      while (rem > 0) begin
        n = (rem > 16) ? 16 : rem;
        t.addr = a; t.len = 8'(n - 1);
        exp_ar.push_back(t);
        a = a + 32'(n * 4);
        rem -= n;
      end
    end
  endtask

  task automatic cmp_ars(input string tag);
    ar_t e;
    check({tag, "_ar_count"}, 64'(ar_obs.size() - ar_rd), 64'(exp_ar.size()));
    while (exp_ar.size() > 0) begin
      e = exp_ar.pop_front();
      if (ar_rd < ar_obs.size()) begin
        check({tag, "_araddr"}, 64'(ar_obs[ar_rd].addr), 64'(e.addr));
        check({tag, "_arlen"},  64'(ar_obs[ar_rd].len),  64'(e.len));
        ar_rd++;
      end
    end
    ar_rd = ar_obs.size();
  endtask

  task automatic cmp_stream(input string tag);
    beat_t e;
    check({tag, "_beat_count"}, 64'(st_obs.size() - st_rd), 64'(exp_st.size()));
    while (exp_st.size() > 0) begin
      e = exp_st.pop_front();
      if (st_rd < st_obs.size()) begin
        check({tag, "_beat"}, 64'(st_obs[st_rd]), 64'(e));
        st_rd++;
      end
    end
    st_rd = st_obs.size();
  endtask

  task automatic wait_irq(input string tag, input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (irq_cnt >= target) break;
      tick();
    end
    repeat (4) tick();
    check({tag, "_irq_count"}, 64'(irq_cnt), 64'(target));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    logic [31:0] d;
    d = 32'd1;
    for (int i = 0; i < budget; i++) begin
      ctrl_rd(5'h14, d);
      if (d[0] == 1'b0) break;
    end
    check({tag, "_busy"}, 64'(d[0]), 64'd0);
  endtask

  initial begin : main
    logic [31:0] d;
    int          base;
    n_vec = 0; n_err = 0; ar_rd = 0; st_rd = 0; irq_exp = 0;
    r_en = 1'b1; bp_mode = 1'b0; err_beat = -1;
    rst = 1'b1; mst_axi_arready = 1'b0;
    ctrl_address = '0; ctrl_read = 1'b0; ctrl_write = 1'b0; ctrl_writedata = '0;
    repeat (3) tick();
    check("rst_arvalid", 64'(mst_axi_arvalid), 64'd0);
    check("rst_araddr",  64'(mst_axi_araddr),  64'd0);
    check("rst_irq",     64'(irq_frame),       64'd0);
    check("rst_rdvalid", 64'(ctrl_readdatavalid), 64'd0);
    check("rst_sop",     64'({st_valid, st_startofpacket, st_endofline, st_endofpacket}), 64'd0);
    check("ar_consts",   64'({mst_axi_arsize, mst_axi_arburst, mst_axi_arid, ctrl_waitrequest}),
          64'({3'd2, 2'b01, 4'd0, 1'b0}));
    rst = 1'b0;
    tick();
    ctrl_rd(5'h14, d); check("status_reset", 64'(d), 64'd0);
    ctrl_rd(5'h04, d); check("lw_reset", 64'(d), 64'd0);

    // Single-shot 40x3 frame with line-clipped bursts
    mst_axi_arready = 1'b1;
    ctrl_wr(5'h00, 32'h1000); ctrl_wr(5'h04, 32'd40); ctrl_wr(5'h08, 32'd3); ctrl_wr(5'h0C, 32'h200);
    ctrl_rd(5'h0C, d); check("stride_rb", 64'(d), 64'h200);
    ctrl_wr(5'h18, 32'hDEAD_BEEF);
    ctrl_rd(5'h18, d); check("unmapped_rd", 64'(d), 64'd0);
    push_ars(32'h1000, 40, 3, 32'h200);
    push_frame(32'h1000, 40, 3, 32'h200, 3);
    ctrl_wr(5'h10, 32'h1);
    irq_exp++;
    wait_irq("single", irq_exp, 2000);
    cmp_ars("single"); cmp_stream("single");
    ctrl_rd(5'h14, d); check("single_status", 64'(d), 64'h0001_0000);

    // 1x1 frame: SOP, EOL, EOP on the same beat
    ctrl_wr(5'h00, 32'h40); ctrl_wr(5'h04, 32'd1); ctrl_wr(5'h08, 32'd1);
    push_ars(32'h40, 1, 1, 32'h200);
    push_frame(32'h40, 1, 1, 32'h200, 1);
    ctrl_wr(5'h10, 32'h1);
    irq_exp++;
    wait_irq("one", irq_exp, 200);
    cmp_ars("one"); cmp_stream("one");

    // Outstanding limit with the R channel stalled
    r_en = 1'b0;
    base = ar_obs.size();
    ctrl_wr(5'h00, 32'h8000); ctrl_wr(5'h04, 32'd16); ctrl_wr(5'h08, 32'd8); ctrl_wr(5'h0C, 32'h40);
    push_ars(32'h8000, 16, 8, 32'h40);
    push_frame(32'h8000, 16, 8, 32'h40, 8);
    ctrl_wr(5'h10, 32'h1);
    repeat (30) tick();
    check("ost_ar_count", 64'(ar_obs.size() - base), 64'd4);
    check("ost_arvalid",  64'(mst_axi_arvalid), 64'd0);
    r_en = 1'b1;
    irq_exp++;
    wait_irq("ost", irq_exp, 2000);
    cmp_ars("ost"); cmp_stream("ost");

    // Random stream backpressure
    bp_mode = 1'b1;
    ctrl_wr(5'h00, 32'hA000); ctrl_wr(5'h04, 32'd20); ctrl_wr(5'h08, 32'd3); ctrl_wr(5'h0C, 32'h80);
    push_ars(32'hA000, 20, 3, 32'h80);
    push_frame(32'hA000, 20, 3, 32'h80, 3);
    ctrl_wr(5'h10, 32'h1);
    irq_exp++;
    wait_irq("bp", irq_exp, 3000);
    bp_mode = 1'b0;
    check("bp_rready_track", 64'(rr_bad), 64'd0);
    cmp_ars("bp"); cmp_stream("bp");

    // Continuous mode; START_ADDR change only affects the next frame
    base = ar_obs.size();
    ctrl_wr(5'h00, 32'h2000); ctrl_wr(5'h04, 32'd8); ctrl_wr(5'h08, 32'd2); ctrl_wr(5'h0C, 32'h100);
    push_ars(32'h2000, 8, 2, 32'h100);
    push_ars(32'h3000, 8, 2, 32'h100);
    push_frame(32'h2000, 8, 2, 32'h100, 2);
    push_frame(32'h3000, 8, 2, 32'h100, 2);
    ctrl_wr(5'h10, 32'h3);
    for (int i = 0; i < 100; i++) begin
      if (ar_obs.size() > base) break;
      tick();
    end
    ctrl_wr(5'h00, 32'h3000);
    irq_exp++;
    wait_irq("cont1", irq_exp, 500);
    ctrl_wr(5'h10, 32'h1);
    irq_exp++;
    wait_irq("cont2", irq_exp, 500);
    cmp_ars("cont"); cmp_stream("cont");
    wait_idle("cont", 20);

    // Disable after two accepted ARs
    mst_axi_arready = 1'b0;
    base = ar_obs.size();
    ctrl_wr(5'h00, 32'hC000); ctrl_wr(5'h04, 32'd16); ctrl_wr(5'h08, 32'd4); ctrl_wr(5'h0C, 32'h40);
    push_ars(32'hC000, 16, 2, 32'h40);
    push_frame(32'hC000, 16, 2, 32'h40, 4);
    ctrl_wr(5'h10, 32'h1);
    for (int i = 0; i < 50; i++) begin
      if (mst_axi_arvalid) break;
      tick();
    end
    mst_axi_arready = 1'b1;
    tick();
    mst_axi_arready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (mst_axi_arvalid) break;
      tick();
    end
    mst_axi_arready = 1'b1;
    ctrl_address = 5'h10; ctrl_writedata = 32'h0; ctrl_write = 1'b1;
    tick();
    ctrl_write = 1'b0;
    repeat (20) tick();
    check("abort_ar_count", 64'(ar_obs.size() - base), 64'd2);
    check("abort_arvalid",  64'(mst_axi_arvalid), 64'd0);
    wait_idle("abort", 50);
    check("abort_no_irq", 64'(irq_cnt), 64'(irq_exp));
    cmp_ars("abort"); cmp_stream("abort");

    // Error response on one beat; next frame must start with SOP again
    ctrl_wr(5'h00, 32'h5000); ctrl_wr(5'h04, 32'd4); ctrl_wr(5'h08, 32'd2); ctrl_wr(5'h0C, 32'h10);
    push_ars(32'h5000, 4, 2, 32'h10);
    push_frame(32'h5000, 4, 2, 32'h10, 2);
    err_beat = rbeats + 2;
    ctrl_wr(5'h10, 32'h1);
    irq_exp++;
    wait_irq("err", irq_exp, 300);
    cmp_ars("err"); cmp_stream("err");
    ctrl_rd(5'h14, d); check("err_sticky", 64'(d), 64'((32'(irq_exp) << 16) | 32'h2));
    ctrl_wr(5'h10, 32'h4);
    ctrl_rd(5'h14, d); check("err_clear", 64'(d), 64'(32'(irq_exp) << 16));
    check("ar_stability", 64'(ar_stab_bad), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
